syndrome_frame_packer: RTL

- Upstream serializer for Helios_single_FPGA. Accepts one measurement round per handshake as a padded bit vector and turns it into the decoder's 8-bit input stream.
- Stream format: START_DECODING_MSG once after reset; then, per frame, MEASUREMENT_DATA_HEADER followed by BYTES_PER_ROUND*GRID_WIDTH_U measurement bytes.
- Sits between the syndrome source and the input byte FIFO. Throttles to one outstanding frame until the downstream result path pulses frame_done.

---
 rtl/syndrome_frame_packer_if.sv | 31 +++
 rtl/syndrome_frame_packer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/syndrome_frame_packer_if.sv
//------------------------------------------------------------------------------
// syndrome_frame_packer_if
// Round input and byte output handshakes of the syndrome frame packer.
// master: packer side (consumes rounds, produces bytes).
// slave : environment side (produces rounds, consumes bytes).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface syndrome_frame_packer_if #(
  parameter int ALIGNED_W = 8
);
  logic [ALIGNED_W-1:0] round_data;
  logic                 round_valid;
  logic                 round_ready;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    input  round_data, round_valid, out_ready,
    output round_ready, out_data, out_valid
  );

  modport slave (
    output round_data, round_valid, out_ready,
    input  round_ready, out_data, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/syndrome_frame_packer.sv
//------------------------------------------------------------------------------
// syndrome_frame_packer
// Serialises measurement rounds into the decoder byte stream: a start byte
// once after reset, then per frame a header plus GRID_WIDTH_U rounds of
// BYTES_PER_ROUND bytes each, LSB byte first. One frame outstanding at a time.
// Optional feature (macro PACKER_CHECKSUM_EN): trailing XOR checksum byte.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module syndrome_frame_packer #(
  parameter int         GRID_WIDTH_X            = 4,
  parameter int         GRID_WIDTH_Z            = 2,
  parameter int         GRID_WIDTH_U            = 5,
  parameter logic [7:0] START_DECODING_MSG      = 8'h01,
  parameter logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02
) (
  input  logic                   clk,
  input  logic                   reset,
  syndrome_frame_packer_if.master bus,
  input  logic                   frame_done,
  output logic                   busy,
  output logic [15:0]            frames_sent
);

  localparam int PUS             = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int BYTES_PER_ROUND = (PUS + 7) >> 3;
  localparam int ALIGNED_W       = BYTES_PER_ROUND * 8;
  localparam int BYTE_W          = $clog2(BYTES_PER_ROUND + 1);
  localparam int ROUND_W         = $clog2(GRID_WIDTH_U + 1);
  localparam logic [BYTE_W-1:0]  LAST_BYTE  = BYTE_W'(BYTES_PER_ROUND - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(GRID_WIDTH_U - 1);

`ifdef PACKER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_START, S_IDLE, S_HEADER, S_LOAD, S_SEND, S_WAIT, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_START, S_IDLE, S_HEADER, S_LOAD, S_SEND, S_WAIT
  } state_t;
`endif

  state_t               state;
  logic [ALIGNED_W-1:0] shift;
  logic [ALIGNED_W-1:0] shift_next;
  logic [ALIGNED_W-1:0] pad_mask;
  logic [ALIGNED_W-1:0] round_masked;
  logic [BYTE_W-1:0]    byte_cnt;
  logic [ROUND_W-1:0]   round_cnt;
`ifdef PACKER_CHECKSUM_EN
  logic [7:0]           acc;
`endif

  // Padding bits above the last PU are forced to zero before serialisation.
  if (ALIGNED_W > PUS) begin : g_pad
    assign pad_mask = {{(ALIGNED_W - PUS){1'b0}}, {PUS{1'b1}}};
  end else begin : g_nopad
    assign pad_mask = '1;
  end

  assign round_masked = bus.round_data & pad_mask;
  assign shift_next   = shift >> 8;

  // Frame sequencing FSM; every handshake output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_START;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= 8'h00;
      bus.round_ready <= 1'b0;
      busy            <= 1'b0;
      frames_sent     <= 16'd0;
      round_cnt       <= '0;
      byte_cnt        <= '0;
      shift           <= '0;
`ifdef PACKER_CHECKSUM_EN
      acc             <= 8'h00;
`endif
    end else begin
      case (state)
        S_START: begin
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= START_DECODING_MSG;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= S_IDLE;
          end
        end
        S_IDLE: begin
          // Round is only peeked here; it is consumed later in S_LOAD.
          if (bus.round_valid) begin
            busy          <= 1'b1;
            bus.out_valid <= 1'b1;
            bus.out_data  <= MEASUREMENT_DATA_HEADER;
            state         <= S_HEADER;
          end
        end
        S_HEADER: begin
`ifdef PACKER_CHECKSUM_EN
          acc <= 8'h00;
`endif
          if (bus.out_ready) begin
            bus.out_valid   <= 1'b0;
            bus.round_ready <= 1'b1;
            round_cnt       <= '0;
            state           <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.round_valid) begin
            bus.round_ready <= 1'b0;
            shift           <= round_masked;
            bus.out_data    <= round_masked[7:0];
            bus.out_valid   <= 1'b1;
            byte_cnt        <= '0;
            state           <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.out_ready) begin
`ifdef PACKER_CHECKSUM_EN
            acc <= acc ^ bus.out_data;
`endif
            if (byte_cnt == LAST_BYTE) begin
              if (round_cnt == LAST_ROUND) begin
`ifdef PACKER_CHECKSUM_EN
                // Checksum includes the byte being accepted right now.
                bus.out_data <= acc ^ bus.out_data;
                state        <= S_CHK;
`else
                bus.out_valid <= 1'b0;
                frames_sent   <= frames_sent + 16'd1;
                state         <= S_WAIT;
`endif
              end else begin
                round_cnt       <= round_cnt + ROUND_W'(1);
                bus.out_valid   <= 1'b0;
                bus.round_ready <= 1'b1;
                state           <= S_LOAD;
              end
            end else begin
              byte_cnt     <= byte_cnt + BYTE_W'(1);
              shift        <= shift_next;
              bus.out_data <= shift_next[7:0];
            end
          end
        end
`ifdef PACKER_CHECKSUM_EN
        S_CHK: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            frames_sent   <= frames_sent + 16'd1;
            state         <= S_WAIT;
          end
        end
`endif
        S_WAIT: begin
          // Only a pulse seen while already waiting releases the frame.
          if (frame_done) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_START;
      endcase
    end
  end

endmodule

`default_nettype wire
